// File: rtl/hdlc_mon_pkg.sv
// Shared types, line patterns and a saturating-add helper for the HDLC line
// monitor. Imported by the per-channel monitor and the top level.
package hdlc_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLAG  = 2'd1,
    FRAME = 2'd2,
    ABORT = 2'd3
  } line_state_t;

  localparam logic [7:0] FLAG_PAT  = 8'h7E;
  localparam logic [7:0] ABORT_PAT = 8'h7F;
  localparam logic [7:0] IDLE_PAT  = 8'hFF;
  localparam logic [6:0] STUFF_PAT = 7'b0111110;

  // a + b clamped to 2^w - 1 (w <= 32); callers truncate to their width.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (33'd1 << w) - 33'd1;
    return (s > mx) ? mx[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/hdlc_line_monitor_ch.sv
// One channel of the HDLC line monitor: 8-bit sampling window, line-state FSM,
// FlagDetect/AbortSignal latency checks and registered event pulses.
// Ports:
//   clk, rst          clock, async active-high reset
//   enable            channel enable; low holds the channel in its reset state
//   line              serial bit, one per clock
//   valid_frame       DUT frame-valid (qualifies abort expectations)
//   flag_detect       DUT flag response under check
//   abort_signal      DUT abort response under check
//   *_seen, *_err     1-cycle registered pulses
//   line_state        current line_state_t
module hdlc_line_monitor_ch
  import hdlc_mon_pkg::*;
#(
  parameter int FLAG_LAT  = 2,
  parameter int ABORT_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       line,
  input  logic       valid_frame,
  input  logic       flag_detect,
  input  logic       abort_signal,
  output logic       flag_seen,
  output logic       abort_seen,
  output logic       idle_seen,
  output logic       stuff_seen,
  output logic       flag_err,
  output logic       abort_err,
  output logic [1:0] line_state
);

  logic [7:0]           sr, sr_next;
  line_state_t          state, state_nx;
  logic [2:0]           gap, gap_nx;
  logic [FLAG_LAT-1:0]  flag_vld_pipe;
  logic [ABORT_LAT-1:0] abort_vld_pipe;
  logic                 is_flag, is_abort, is_idle, is_stuff;

  // Patterns are judged on the window including the bit sampled this edge.
  always_comb begin
    sr_next  = {sr[6:0], line};
    is_flag  = (sr_next == FLAG_PAT);
    is_abort = (sr_next == ABORT_PAT);
    is_idle  = (sr_next == IDLE_PAT) && (sr != IDLE_PAT);
    is_stuff = (sr_next[6:0] == STUFF_PAT) && (state == FRAME);
  end

  // Next state; idle beats abort beats flag. In FLAG, gap counts non-flag
  // samples and the eighth one moves the line into FRAME.
  always_comb begin
    state_nx = state;
    gap_nx   = gap;
    if (is_idle) begin
      state_nx = IDLE;
    end else if (is_abort && state == FRAME) begin
      state_nx = ABORT;
    end else if (is_flag) begin
      state_nx = FLAG;
      gap_nx   = 3'd0;
    end else if (state == FLAG) begin
      if (gap == 3'd7) state_nx = FRAME;
      else             gap_nx   = gap + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gap   <= 3'd0;
    end else if (!enable) begin
      state <= IDLE;
      gap   <= 3'd0;
    end else begin
      state <= state_nx;
      gap   <= gap_nx;
    end
  end

  // Each detected flag/abort enters its latency pipe; the top bit is the
  // expectation falling due on this edge, checked against the DUT response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr             <= IDLE_PAT;
      flag_vld_pipe  <= '0;
      abort_vld_pipe <= '0;
      flag_seen      <= 1'b0;
      abort_seen     <= 1'b0;
      idle_seen      <= 1'b0;
      stuff_seen     <= 1'b0;
      flag_err       <= 1'b0;
      abort_err      <= 1'b0;
    end else if (!enable) begin
      sr             <= IDLE_PAT;
      flag_vld_pipe  <= '0;
      abort_vld_pipe <= '0;
      flag_seen      <= 1'b0;
      abort_seen     <= 1'b0;
      idle_seen      <= 1'b0;
      stuff_seen     <= 1'b0;
      flag_err       <= 1'b0;
      abort_err      <= 1'b0;
    end else begin
      sr             <= sr_next;
      flag_vld_pipe  <= FLAG_LAT'({flag_vld_pipe, is_flag});
      abort_vld_pipe <= ABORT_LAT'({abort_vld_pipe, is_abort & valid_frame});
      flag_seen      <= is_flag;
      abort_seen     <= is_abort;
      idle_seen      <= is_idle;
      stuff_seen     <= is_stuff;
      flag_err       <= flag_vld_pipe[FLAG_LAT-1] & ~flag_detect;
      abort_err      <= abort_vld_pipe[ABORT_LAT-1] & ~abort_signal;
    end
  end

  assign line_state = state;

endmodule

// File: rtl/hdlc_line_monitor.sv
// HDLC serial-line monitor/checker for N_CH lines. Instantiates one channel
// monitor per line and keeps the saturating flag and error counters.
// Ports:
//   Clk, Rst                      clock, async active-high reset
//   Enable, Line                  per-channel enable and serial bit
//   ValidFrame_in, FlagDetect_in,
//   AbortSignal_in                DUT indications under check
//   Clear                         synchronous clear of all counters
//   FlagSeen..AbortErr            per-channel 1-cycle pulses
//   LineState                     packed 2-bit state per channel
//   FlagCnt                       packed CNT_W flag count per channel
//   ErrCnt                        total FlagErr + AbortErr pulses
module hdlc_line_monitor
  import hdlc_mon_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int CNT_W     = 16,
  parameter int FLAG_LAT  = 2,
  parameter int ABORT_LAT = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [N_CH-1:0]       Enable,
  input  logic [N_CH-1:0]       Line,
  input  logic [N_CH-1:0]       ValidFrame_in,
  input  logic [N_CH-1:0]       FlagDetect_in,
  input  logic [N_CH-1:0]       AbortSignal_in,
  input  logic                  Clear,
  output logic [N_CH-1:0]       FlagSeen,
  output logic [N_CH-1:0]       AbortSeen,
  output logic [N_CH-1:0]       IdleSeen,
  output logic [N_CH-1:0]       StuffSeen,
  output logic [N_CH-1:0]       FlagErr,
  output logic [N_CH-1:0]       AbortErr,
  output logic [N_CH*2-1:0]     LineState,
  output logic [N_CH*CNT_W-1:0] FlagCnt,
  output logic [CNT_W-1:0]      ErrCnt
);

  logic [31:0] err_inc;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    hdlc_line_monitor_ch #(
      .FLAG_LAT  (FLAG_LAT),
      .ABORT_LAT (ABORT_LAT)
    ) u_ch (
      .clk          (Clk),
      .rst          (Rst),
      .enable       (Enable[g]),
      .line         (Line[g]),
      .valid_frame  (ValidFrame_in[g]),
      .flag_detect  (FlagDetect_in[g]),
      .abort_signal (AbortSignal_in[g]),
      .flag_seen    (FlagSeen[g]),
      .abort_seen   (AbortSeen[g]),
      .idle_seen    (IdleSeen[g]),
      .stuff_seen   (StuffSeen[g]),
      .flag_err     (FlagErr[g]),
      .abort_err    (AbortErr[g]),
      .line_state   (LineState[2*g +: 2])
    );

    // Counts the registered pulse, so it trails FlagSeen by one cycle.
    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
        FlagCnt[g*CNT_W +: CNT_W] <= '0;
      else if (Clear)
        FlagCnt[g*CNT_W +: CNT_W] <= '0;
      else
        FlagCnt[g*CNT_W +: CNT_W] <=
          CNT_W'(sat_add(32'(FlagCnt[g*CNT_W +: CNT_W]), 32'(FlagSeen[g]), CNT_W));
    end
  end

  // Every FlagErr and AbortErr bit is a separate error.
  always_comb begin
    err_inc = '0;
    for (int i = 0; i < N_CH; i++)
      err_inc = err_inc + 32'(FlagErr[i]) + 32'(AbortErr[i]);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)        ErrCnt <= '0;
    else if (Clear) ErrCnt <= '0;
    else            ErrCnt <= CNT_W'(sat_add(32'(ErrCnt), err_inc, CNT_W));
  end

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// Randomised bench for hdlc_line_monitor: directed segments from the test
// plan plus random traffic, every cycle compared against a reference model
// working on 8-bit windows and queues of due-time expectations.
module tb_hdlc_line_monitor;
  localparam int N_CH = 2, CNT_W = 4, FLAG_LAT = 2, ABORT_LAT = 1;
  localparam int CMAX = (1 << CNT_W) - 1;

  logic Clk = 0, Rst = 0, Clear = 0;
  logic [N_CH-1:0] Enable = '1, Line = '1, ValidFrame_in = '0;
  logic [N_CH-1:0] FlagDetect_in = '0, AbortSignal_in = '0;
  logic [N_CH-1:0] FlagSeen, AbortSeen, IdleSeen, StuffSeen, FlagErr, AbortErr;
  logic [N_CH*2-1:0] LineState;
  logic [N_CH*CNT_W-1:0] FlagCnt;
  logic [CNT_W-1:0] ErrCnt;

  hdlc_line_monitor #(.N_CH(N_CH), .CNT_W(CNT_W), .FLAG_LAT(FLAG_LAT), .ABORT_LAT(ABORT_LAT)) dut (
    .Clk(Clk), .Rst(Rst), .Enable(Enable), .Line(Line), .ValidFrame_in(ValidFrame_in),
    .FlagDetect_in(FlagDetect_in), .AbortSignal_in(AbortSignal_in), .Clear(Clear),
    .FlagSeen(FlagSeen), .AbortSeen(AbortSeen), .IdleSeen(IdleSeen), .StuffSeen(StuffSeen),
    .FlagErr(FlagErr), .AbortErr(AbortErr), .LineState(LineState), .FlagCnt(FlagCnt),
    .ErrCnt(ErrCnt));

  always #5 Clk = ~Clk;

  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int cyc = 0;                      // index of the next sampling edge
  int m_win[N_CH], m_st[N_CH], m_nf[N_CH];
  int fq[N_CH][$], aq[N_CH][$];     // due edges of pending responses
  logic [N_CH-1:0] e_fs, e_as, e_is, e_ss, e_fe, e_ae;
  int e_fc[N_CH], e_ec;
  bit bq[N_CH][$];                  // pending line bits per channel
  int fmode = 0, amode = 0;         // 0 answer when due, 1 never answer, 2 random
  bit rnd = 0;                      // random traffic once bq drains

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_win[c] = 255; m_st[c] = 0; m_nf[c] = 0; e_fc[c] = 0;
      fq[c].delete(); aq[c].delete();
    end
    e_fs = '0; e_as = '0; e_is = '0; e_ss = '0; e_fe = '0; e_ae = '0; e_ec = 0;
  endtask

  task automatic model_edge();
    int nw;
    bit fl, ab, id, st;
    if (Clear) begin
      for (int c = 0; c < N_CH; c++) e_fc[c] = 0;
      e_ec = 0;
    end else begin
      for (int c = 0; c < N_CH; c++) if (e_fs[c] && e_fc[c] < CMAX) e_fc[c]++;
      e_ec = e_ec + $countones(e_fe) + $countones(e_ae);
      if (e_ec > CMAX) e_ec = CMAX;
    end
    e_fs = '0; e_as = '0; e_is = '0; e_ss = '0; e_fe = '0; e_ae = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (!Enable[c]) begin
        m_win[c] = 255; m_st[c] = 0; fq[c].delete(); aq[c].delete();
        continue;
      end
      nw = ((m_win[c] << 1) | int'(Line[c])) & 255;
      fl = (nw == 'h7E);
      ab = (nw == 'h7F);
      id = (nw == 255) && (m_win[c] != 255);
      st = ((nw & 127) == 'h3E) && (m_st[c] == 2);
      if (fq[c].size() > 0 && fq[c][0] == cyc) begin
        void'(fq[c].pop_front());
        if (!FlagDetect_in[c]) e_fe[c] = 1;
      end
      if (aq[c].size() > 0 && aq[c][0] == cyc) begin
        void'(aq[c].pop_front());
        if (!AbortSignal_in[c]) e_ae[c] = 1;
      end
      if (fl) fq[c].push_back(cyc + FLAG_LAT);
      if (ab && ValidFrame_in[c]) aq[c].push_back(cyc + ABORT_LAT);
      e_fs[c] = fl; e_as[c] = ab; e_is[c] = id; e_ss[c] = st;
      if (id) m_st[c] = 0;
      else if (ab && m_st[c] == 2) m_st[c] = 3;
      else if (fl) begin m_st[c] = 1; m_nf[c] = 0; end
      else if (m_st[c] == 1) begin
        if (m_nf[c] == 7) m_st[c] = 2; else m_nf[c]++;
      end
      m_win[c] = nw;
    end
    cyc++;
  endtask

  task automatic check_all();
    logic [N_CH*2-1:0] els;
    logic [N_CH*CNT_W-1:0] efc;
    for (int c = 0; c < N_CH; c++) begin
      els[2*c +: 2] = 2'(m_st[c]);
      efc[c*CNT_W +: CNT_W] = CNT_W'(e_fc[c]);
    end
    chk("flag_seen", 32'(FlagSeen), 32'(e_fs));
    chk("abort_seen", 32'(AbortSeen), 32'(e_as));
    chk("idle_seen", 32'(IdleSeen), 32'(e_is));
    chk("stuff_seen", 32'(StuffSeen), 32'(e_ss));
    chk("flag_err", 32'(FlagErr), 32'(e_fe));
    chk("abort_err", 32'(AbortErr), 32'(e_ae));
    chk("line_state", 32'(LineState), 32'(els));
    chk("flag_cnt", 32'(FlagCnt), 32'(efc));
    chk("err_cnt", 32'(ErrCnt), 32'(e_ec));
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_pulses"}, 32'({FlagSeen, AbortSeen, IdleSeen, StuffSeen, FlagErr, AbortErr}), 0);
    chk({tag, "_state"}, 32'(LineState), 0);
    chk({tag, "_fcnt"}, 32'(FlagCnt), 0);
    chk({tag, "_ecnt"}, 32'(ErrCnt), 0);
  endtask

  // ---------------- stimulus ----------------
  task automatic push_byte(input int c, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bq[c].push_back(b[i]);
  endtask

  task automatic push_ones(input int c, input int n);
    repeat (n) bq[c].push_back(1'b1);
  endtask

  task automatic push_rand_seg(input int c);
    case ($urandom % 6)
      0: push_byte(c, 8'h7E);
      1: push_byte(c, 8'h7F);
      2: push_byte(c, 8'hFF);
      5: push_byte(c, 8'h3E);
      default: push_byte(c, 8'($urandom));
    endcase
  endtask

  function automatic logic resp(input int mode, input bit due);
    case (mode)
      0: return due | 1'($urandom % 2);
      1: return 1'b0;
      default: return ($urandom % 4) != 0;
    endcase
  endfunction

  // Drive one cycle's inputs at the falling edge, model the rising edge,
  // check outputs at the next falling edge.
  task automatic run(input int n);
    repeat (n) begin
      for (int c = 0; c < N_CH; c++) begin
        if (bq[c].size() == 0 && rnd) push_rand_seg(c);
        Line[c] = (bq[c].size() > 0) ? bq[c].pop_front() : 1'b1;
        FlagDetect_in[c]  = resp(fmode, fq[c].size() > 0 && fq[c][0] == cyc);
        AbortSignal_in[c] = resp(amode, aq[c].size() > 0 && aq[c][0] == cyc);
      end
      @(posedge Clk);
      model_edge();
      @(negedge Clk);
      check_all();
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((bq[0].size() > 0 || bq[1].size() > 0) && n < 2000) begin run(1); n++; end
    run(FLAG_LAT + ABORT_LAT + 3);
  endtask

  initial begin
    model_reset();
    #1 Rst = 1;
    repeat (2) @(negedge Clk);
    reset_chk("por");
    Rst = 0;

    // Flag after idle line, response on time
    ValidFrame_in = '1;
    push_ones(0, 16); push_byte(0, 8'h7E); push_ones(1, 24);
    drain();
    chk("a_fcnt0", 32'(FlagCnt[CNT_W-1:0]), 1);
    chk("a_ecnt", 32'(ErrCnt), 0);

    // Same flag, response missing
    fmode = 1;
    push_ones(0, 8); push_byte(0, 8'h7E);
    drain();
    chk("b_ecnt", 32'(ErrCnt), 1);

    // Stuffed zero inside a frame
    fmode = 0;
    push_byte(0, 8'h7E); bq[0].push_back(1'b1); push_byte(0, 8'hF7); push_byte(0, 8'hBE);
    push_ones(0, 3);
    drain();

    // Abort inside a valid frame, response missing then present
    amode = 1;
    push_byte(0, 8'h7E); push_byte(0, 8'hA5); push_byte(0, 8'hA5); push_byte(0, 8'h7F);
    drain();
    chk("d_ecnt_miss", 32'(ErrCnt), 2);
    amode = 0;
    push_byte(0, 8'h7E); push_byte(0, 8'hA5); push_byte(0, 8'hA5); push_byte(0, 8'h7F);
    drain();
    chk("d_ecnt_ok", 32'(ErrCnt), 2);

    // Missed flags on both channels: saturate, then Clear during an error cycle
    fmode = 1;
    for (int c = 0; c < N_CH; c++) repeat (22) push_byte(c, 8'h7E);
    run(20 * 8 + 4);
    chk("e_ecnt_sat", 32'(ErrCnt), CMAX);
    begin
      int n = 0;
      while (e_fe == '0 && n < 40) begin run(1); n++; end
      chk("e_err_wait", 32'(e_fe != '0), 1);
      Clear = 1;
      run(1);
      Clear = 0;
      chk("e_clear", 32'(ErrCnt), 0);
    end
    drain();

    // Reset while a flag response is still pending
    push_ones(0, 8); push_byte(0, 8'h7E);
    begin
      int n = 0;
      while (!e_fs[0] && n < 60) begin run(1); n++; end
      chk("f_flag_wait", 32'(e_fs[0]), 1);
    end
    Rst = 1;
    #1 reset_chk("arst");
    model_reset();
    for (int c = 0; c < N_CH; c++) bq[c].delete();
    repeat (2) @(negedge Clk);
    Rst = 0;
    run(8);

    // Channel 1 disabled under traffic
    fmode = 2; amode = 2; rnd = 1;
    Enable = 2'b01;
    run(100);
    chk("g_ls1", 32'(LineState[3:2]), 0);
    Enable = '1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin fmode = $urandom % 3; amode = $urandom % 3; end
      if ($urandom % 200 == 0) Enable[$urandom % N_CH] ^= 1'b1;
      Clear = ($urandom % 150) == 0;
      ValidFrame_in = N_CH'($urandom) | N_CH'($urandom);
      run(1);
    end
    Clear = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hdlc_line_monitor.md
Name: hdlc_line_monitor

Overview:
- Synthesizable, parametrised HDLC serial-line monitor/checker; replaces simulation-only concurrent checks with RTL usable in both bench and FPGA debug builds.
- Watches N_CH serial lines (e.g. Rx, Tx) and classifies flag, abort, idle and stuffed-zero patterns per channel.
- Cross-checks the DUT's FlagDetect/AbortSignal responses at configurable latencies.
- Counts flags and errors.

Parameters:
- N_CH, 2, number of monitored serial channels.
- CNT_W, 16, width of all saturating counters.
- FLAG_LAT, 2, samples from last flag bit to required FlagDetect_in (1..7).
- ABORT_LAT, 1, samples from abort completion to required AbortSignal_in (1..7).

Ports:
- Clk  in  1  system clock, all sampling on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Enable  in  N_CH  per-channel monitor enable.
- Line  in  N_CH  serial line bit per channel, one bit per clock.
- ValidFrame_in  in  N_CH  DUT frame-valid indication per channel.
- FlagDetect_in  in  N_CH  DUT flag-detect response to check.
- AbortSignal_in  in  N_CH  DUT abort response to check.
- Clear  in  1  synchronous clear of all counters.
- FlagSeen  out  N_CH  1-cycle pulse: flag window completed.
- AbortSeen  out  N_CH  1-cycle pulse: abort window completed.
- IdleSeen  out  N_CH  1-cycle pulse: entry into idle.
- StuffSeen  out  N_CH  1-cycle pulse: stuffed zero inside frame.
- FlagErr  out  N_CH  1-cycle pulse: required FlagDetect_in missing.
- AbortErr  out  N_CH  1-cycle pulse: required AbortSignal_in missing.
- LineState  out  N_CH*2  packed per-channel state (IDLE/FLAG/FRAME/ABORT).
- FlagCnt  out  N_CH*CNT_W  packed per-channel flag counts.
- ErrCnt  out  CNT_W  total error count, all channels.

Behaviour:
- Reset: per channel, sr=8'hFF, state IDLE, latency pipelines 0. All pulse outputs 0, all counters 0.
- Per enabled channel, each edge: sr_next={sr[6:0],Line}; sr[7] is the oldest bit.
- Detects on sr_next:
  - flag = 8'h7E (0111_1110).
  - abort = 8'h7F.
  - idle = 8'hFF with sr!=8'hFF.
  - stuff = sr_next[6:0]==7'b0111110 and state==FRAME.
- Event pulses are registered: visible the cycle after the sampling edge of the last pattern bit.
- State machine:
  - IDLE→FLAG on flag.
  - FLAG→FLAG on flag.
  - FLAG→FRAME after 8 consecutive samples without flag (3-bit counter, cleared on each flag).
  - FRAME→FLAG on flag.
  - FRAME→ABORT on abort.
  - any→IDLE on idle.
  - ABORT→FLAG on flag.
  - Precedence: idle > abort > flag.
- FlagErr check:
  - A flag sampled at edge t pushes a 1 into a FLAG_LAT-deep pipeline.
  - At edge t+FLAG_LAT, if FlagDetect_in==0, FlagErr pulses the following cycle.
- AbortErr check:
  - An abort with ValidFrame_in==1 on the same edge pushes a 1 into an ABORT_LAT-deep pipeline.
  - Missing AbortSignal_in at edge t+ABORT_LAT pulses AbortErr the same way.
  - Aborts outside ValidFrame_in are reported via AbortSeen only.
- Back-to-back flags (shared 0 not allowed; 16-bit 7E7E) each push independently; overlapping expectations are checked individually.
- Enable low:
  - sr forced to 8'hFF, state IDLE, pipelines flushed, no pulses.
  - Counters hold.
  - Re-enable behaves as post-reset for that channel.
- Counters:
  - FlagCnt[ch] +1 per FlagSeen.
  - ErrCnt += popcount(FlagErr|AbortErr across all bits, FlagErr and AbortErr counted separately) per cycle.
  - All counters saturate at 2^CNT_W-1, never wrap.
- Clear has priority over increments in the same cycle.
- Rst mid-frame: immediate asynchronous return to reset values; in-flight expectations are dropped, not reported.

Decomposition:
- Package hdlc_mon_pkg:
  - line_state_t enum (IDLE=0, FLAG=1, FRAME=2, ABORT=3).
  - FLAG_PAT=8'h7E, ABORT_PAT=8'h7F, IDLE_PAT=8'hFF, STUFF_PAT=7'b0111110.
  - saturating-add function.
- Sub-module hdlc_line_monitor_ch: one channel's sr, FSM, latency pipelines and pulses; generated N_CH times.
- Top level holds FlagCnt, ErrCnt and Clear logic.

Test Plan:
- Idle 16×'1', then 0111_1110 on ch0, FlagDetect_in driven 2 cycles after last bit → FlagSeen pulse once, LineState IDLE→FLAG, FlagCnt[0]=1, ErrCnt=0.
- Same flag with FlagDetect_in held 0 → FlagErr[0] pulses exactly once at edge t+3; ErrCnt=1.
- Flag, 16 data bits, then 0111_1111 with ValidFrame_in=1 and AbortSignal_in=0 → AbortSeen then AbortErr pulse, state ABORT, ErrCnt=1; repeat with AbortSignal_in=1 at t+1 → ErrCnt unchanged.
- Flag, then data 1111_1011_1110 in FRAME → StuffSeen exactly once (only for the five-ones-then-zero, not for the flag); no FlagSeen.
- CNT_W=4, 20 missed flags on ch0 and ch1 simultaneously → ErrCnt saturates at 15; Clear asserted in an error cycle → ErrCnt=0 next cycle.
- Rst asserted between flag end and t+2 with FlagDetect_in=0 → no FlagErr after release, all outputs at reset values asynchronously; Enable[1]=0 with traffic on Line[1] → no ch1 pulses, LineState[1]=IDLE.
